// File: rtl/ysyx_24100006_clint_mh_pkg.sv
// Shared definitions for the core-local interruptor: register offsets,
// AXI response codes, address decode and byte-strobe merge helpers.
package ysyx_24100006_clint_mh_pkg;

   localparam int MAX_HARTS = 4;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [31:0] OFF_MTIME_LO = 32'h0000_0000;
   localparam logic [31:0] OFF_MTIME_HI = 32'h0000_0004;
   localparam logic [31:0] OFF_MSIP     = 32'h0000_0100;
   localparam logic [31:0] OFF_MTIMECMP = 32'h0000_0200;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_MTIME_LO,
      REG_MTIME_HI,
      REG_MSIP,
      REG_CMP_LO,
      REG_CMP_HI
   } reg_kind_e;

   typedef struct packed {
      reg_kind_e  kind;
      logic [1:0] hart;
   } reg_sel_t;

   typedef enum logic {R_IDLE, R_DATA} r_state_e;
   typedef enum logic {W_IDLE, W_RESP} w_state_e;

   // Snapshot of both bus FSMs, kept together so checkers can bind to one signal.
   typedef struct packed {
      r_state_e r_state;
      w_state_e w_state;
      logic     aw_held;
      logic     w_held;
   } clint_dbg_t;

   // Decode a window-relative offset; only word-aligned offsets of existing harts map.
   function automatic reg_sel_t decode_addr(input logic [31:0] off, input int num_harts);
      reg_sel_t sel;
      sel.kind = REG_NONE;
      sel.hart = 2'd0;
      if (off == OFF_MTIME_LO) begin
         sel.kind = REG_MTIME_LO;
      end else if (off == OFF_MTIME_HI) begin
         sel.kind = REG_MTIME_HI;
      end else if (off[31:4] == OFF_MSIP[31:4] && off[1:0] == 2'b00) begin
         sel.hart = off[3:2];
         if (32'(off[3:2]) < 32'(num_harts)) sel.kind = REG_MSIP;
      end else if (off[31:5] == OFF_MTIMECMP[31:5] && off[1:0] == 2'b00) begin
         sel.hart = off[4:3];
         if (32'(off[4:3]) < 32'(num_harts)) sel.kind = off[2] ? REG_CMP_HI : REG_CMP_LO;
      end
      return sel;
   endfunction

   // Replace only the bytes whose strobe bit is set.
   function automatic logic [31:0] merge32(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/ysyx_24100006_clint_mh_mtime.sv
// Free-running 64-bit machine timer with prescaler, bus write override
// and the high-word shadow used for coherent 64-bit reads.
module ysyx_24100006_clint_mtime
   import ysyx_24100006_clint_mh_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic        wr_hi,
   input  logic [31:0] wr_data,
   input  logic [3:0]  wr_strb,
   input  logic        rd_en,
   input  logic        rd_lo,
   output logic [63:0] mtime,
   output logic [31:0] mtime_hi_rd
);

   logic [7:0]  pre_cnt;
   logic        tick;
   logic [31:0] shadow_hi;
   logic        shadow_vld;

   assign tick = (pre_cnt == 8'(PRESCALE - 1));

   // Prescaler: counts 0..PRESCALE-1, unaffected by bus writes to mtime.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)    pre_cnt <= 8'd0;
      else if (tick) pre_cnt <= 8'd0;
      else           pre_cnt <= pre_cnt + 8'd1;
   end

   // Timer: a bus write takes priority and swallows that cycle's increment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mtime <= 64'd0;
      end else if (wr_en) begin
         if (wr_hi) mtime[63:32] <= merge32(mtime[63:32], wr_data, wr_strb);
         else       mtime[31:0]  <= merge32(mtime[31:0], wr_data, wr_strb);
      end else if (tick) begin
         mtime <= mtime + 64'd1;
      end
   end

   // Shadow: a low-word read snapshots the high word; any other read invalidates it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shadow_hi  <= 32'd0;
         shadow_vld <= 1'b0;
      end else if (rd_en) begin
         if (rd_lo) begin
            shadow_hi  <= mtime[63:32];
            shadow_vld <= 1'b1;
         end else begin
            shadow_vld <= 1'b0;
         end
      end
   end

   assign mtime_hi_rd = shadow_vld ? shadow_hi : mtime[63:32];

endmodule

// File: rtl/ysyx_24100006_clint_mh.sv
// Core-local interruptor: AXI-Lite slave exposing mtime, per-hart msip and
// mtimecmp, and driving registered mtip/msip interrupt lines.
//
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both 1. Once a valid is raised by this block (rvalid, bvalid) it stays
// high with its payload stable until the matching ready is seen. Readies are
// held low while reset is asserted and for the first cycle after release.
module ysyx_24100006_clint_mh
   import ysyx_24100006_clint_mh_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'ha000_0048,
   parameter int          NUM_HARTS = 1,   // 1..MAX_HARTS
   parameter int          PRESCALE  = 1    // 1..255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          axi_araddr,
   input  logic                 axi_arvalid,
   output logic                 axi_arready,
   output logic [31:0]          axi_rdata,
   output logic [1:0]           axi_rresp,
   output logic                 axi_rvalid,
   input  logic                 axi_rready,
   input  logic [31:0]          axi_awaddr,
   input  logic                 axi_awvalid,
   output logic                 axi_awready,
   input  logic [31:0]          axi_wdata,
   input  logic [7:0]           axi_wstrb,
   input  logic                 axi_wvalid,
   output logic                 axi_wready,
   output logic [1:0]           axi_bresp,
   output logic                 axi_bvalid,
   input  logic                 axi_bready,
   output logic [NUM_HARTS-1:0] mtip,
   output logic [NUM_HARTS-1:0] msip
);

   logic        active_q;
   r_state_e    r_state, r_next;
   w_state_e    w_state, w_next;
   logic        ar_fire, aw_fire, w_fire, do_write;
   reg_sel_t    rd_sel, wr_sel;
   logic [31:0] rd_value;
   logic [1:0]  rd_resp;
   logic [31:0] rdata_q;
   logic [1:0]  rresp_q;
   logic        aw_held, w_held;
   logic [31:0] aw_addr_q, w_data_q;
   logic [3:0]  w_strb_q;
   logic [1:0]  bresp_q;
   logic [63:0] mtime;
   logic [31:0] mtime_hi_rd;
   logic [63:0] mtimecmp [NUM_HARTS];
   logic [NUM_HARTS-1:0] msip_q, mtip_q;
   clint_dbg_t  dbg_state;
   logic        unused_bits;

   assign unused_bits = ^{axi_wstrb[7:4], dbg_state};
   assign dbg_state   = '{r_state: r_state, w_state: w_state, aw_held: aw_held, w_held: w_held};

   // Readies stay low until the cycle after reset is released.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) active_q <= 1'b0;
      else        active_q <= 1'b1;
   end

   // ---------------- read channel ----------------
   assign axi_arready = active_q && (r_state == R_IDLE);
   assign axi_rvalid  = (r_state == R_DATA);
   assign axi_rdata   = rdata_q;
   assign axi_rresp   = rresp_q;
   assign ar_fire     = axi_arvalid && axi_arready;
   assign rd_sel      = decode_addr(axi_araddr - BASE_ADDR, NUM_HARTS);

   // Read FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= R_IDLE;
      else        r_state <= r_next;
   end

   // Read FSM next state: one beat of data per accepted address.
   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_fire) r_next = R_DATA;
         R_DATA:  if (axi_rready) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   // Read mux over the current register contents (old value on a same-cycle write).
   always_comb begin
      rd_value = 32'd0;
      rd_resp  = RESP_OKAY;
      case (rd_sel.kind)
         REG_MTIME_LO: rd_value = mtime[31:0];
         REG_MTIME_HI: rd_value = mtime_hi_rd;
         REG_MSIP: begin
            for (int h = 0; h < NUM_HARTS; h++)
               if (rd_sel.hart == 2'(h)) rd_value = {31'd0, msip_q[h]};
         end
         REG_CMP_LO: begin
            for (int h = 0; h < NUM_HARTS; h++)
               if (rd_sel.hart == 2'(h)) rd_value = mtimecmp[h][31:0];
         end
         REG_CMP_HI: begin
            for (int h = 0; h < NUM_HARTS; h++)
               if (rd_sel.hart == 2'(h)) rd_value = mtimecmp[h][63:32];
         end
         default: rd_resp = RESP_SLVERR;
      endcase
   end

   // Read data/response captured at the address handshake and held until taken.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q <= 32'd0;
         rresp_q <= RESP_OKAY;
      end else if (ar_fire) begin
         rdata_q <= rd_value;
         rresp_q <= rd_resp;
      end
   end

   // ---------------- write channel ----------------
   assign axi_awready = active_q && (w_state == W_IDLE) && !aw_held;
   assign axi_wready  = active_q && (w_state == W_IDLE) && !w_held;
   assign axi_bvalid  = (w_state == W_RESP);
   assign axi_bresp   = bresp_q;
   assign aw_fire     = axi_awvalid && axi_awready;
   assign w_fire      = axi_wvalid && axi_wready;
   assign do_write    = (w_state == W_IDLE) && aw_held && w_held;
   assign wr_sel      = decode_addr(aw_addr_q - BASE_ADDR, NUM_HARTS);

   // Write FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) w_state <= W_IDLE;
      else        w_state <= w_next;
   end

   // Write FSM next state: respond once address and data are both held.
   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE:  if (do_write) w_next = W_RESP;
         W_RESP:  if (axi_bready) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   // AW and W are captured independently, in any order, and released on commit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         aw_addr_q <= 32'd0;
         w_data_q  <= 32'd0;
         w_strb_q  <= 4'd0;
         bresp_q   <= RESP_OKAY;
      end else begin
         if (aw_fire) begin
            aw_held   <= 1'b1;
            aw_addr_q <= axi_awaddr;
         end
         if (w_fire) begin
            w_held   <= 1'b1;
            w_data_q <= axi_wdata;
            w_strb_q <= axi_wstrb[3:0];
         end
         if (do_write) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bresp_q <= (wr_sel.kind == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

   // ---------------- registers and interrupts ----------------
   ysyx_24100006_clint_mtime #(
      .PRESCALE(PRESCALE)
   ) u_mtime (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (do_write && (wr_sel.kind == REG_MTIME_LO || wr_sel.kind == REG_MTIME_HI)),
      .wr_hi      (wr_sel.kind == REG_MTIME_HI),
      .wr_data    (w_data_q),
      .wr_strb    (w_strb_q),
      .rd_en      (ar_fire),
      .rd_lo      (rd_sel.kind == REG_MTIME_LO),
      .mtime      (mtime),
      .mtime_hi_rd(mtime_hi_rd)
   );

   // Per-hart msip and mtimecmp; msip only has bit 0, driven by strobe byte 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         msip_q <= '0;
         for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= '1;
      end else if (do_write) begin
         for (int h = 0; h < NUM_HARTS; h++) begin
            if (wr_sel.hart == 2'(h)) begin
               case (wr_sel.kind)
                  REG_MSIP:   if (w_strb_q[0]) msip_q[h] <= w_data_q[0];
                  REG_CMP_LO: mtimecmp[h][31:0]  <= merge32(mtimecmp[h][31:0], w_data_q, w_strb_q);
                  REG_CMP_HI: mtimecmp[h][63:32] <= merge32(mtimecmp[h][63:32], w_data_q, w_strb_q);
                  default:    ;
               endcase
            end
         end
      end
   end

   // Timer interrupt: registered unsigned compare, one cycle behind the operands.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mtip_q <= '0;
      end else begin
         for (int h = 0; h < NUM_HARTS; h++) mtip_q[h] <= (mtime >= mtimecmp[h]);
      end
   end

   assign mtip = mtip_q;
   assign msip = msip_q;

endmodule

// File: tb/tb_ysyx_24100006_clint_mh.sv
// Bench for the core-local interruptor: register table, timer interrupt,
// coherent 64-bit reads, split AW/W, read back-pressure and mid-read reset.
module tb_ysyx_24100006_clint_mh;

   localparam logic [31:0] BASE = 32'ha000_0048;
   localparam int          NH   = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [31:0]   araddr = '0, awaddr = '0, wdata = '0;
   logic          arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
   logic [7:0]    wstrb = '0;
   logic          arready, rvalid, awready, wready, bvalid;
   logic [31:0]   rdata;
   logic [1:0]    rresp, bresp;
   logic [NH-1:0] mtip, msip;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct packed {
      logic        chk;
      logic [1:0]  resp;
      logic [31:0] data;
   } rd_exp_t;

   rd_exp_t    rd_exp_q[$];
   logic [1:0] wr_exp_q[$];

   typedef struct {
      bit          is_wr;
      logic [31:0] off;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [1:0]  resp;
      logic [31:0] rdata;
      logic [1:0]  msip;
   } vec_t;

   vec_t vecs[$];

   ysyx_24100006_clint_mh #(
      .BASE_ADDR(BASE),
      .NUM_HARTS(NH),
      .PRESCALE (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .axi_araddr (araddr),
      .axi_arvalid(arvalid),
      .axi_arready(arready),
      .axi_rdata  (rdata),
      .axi_rresp  (rresp),
      .axi_rvalid (rvalid),
      .axi_rready (rready),
      .axi_awaddr (awaddr),
      .axi_awvalid(awvalid),
      .axi_awready(awready),
      .axi_wdata  (wdata),
      .axi_wstrb  (wstrb),
      .axi_wvalid (wvalid),
      .axi_wready (wready),
      .axi_bresp  (bresp),
      .axi_bvalid (bvalid),
      .axi_bready (bready),
      .mtip       (mtip),
      .msip       (msip)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_true(input string name, input bit cond, input logic [63:0] act);
      tests++;
      if (!cond) begin
         fails++;
         $display("FAIL %s: got %h, condition not met", name, act);
      end
   endtask

   // Scoreboard: pop an expectation for every read/write response the DUT hands over.
   always @(negedge clk) begin
      if (reset && rvalid && rready) begin
         if (rd_exp_q.size() == 0) begin
            check_true("rd_unexpected", 1'b0, {30'd0, rresp, rdata});
         end else begin
            rd_exp_t e;
            e = rd_exp_q.pop_front();
            check("rresp", rresp, e.resp);
            if (e.chk) check("rdata", rdata, e.data);
         end
      end
      if (reset && bvalid && bready) begin
         if (wr_exp_q.size() == 0) check_true("wr_unexpected", 1'b0, bresp);
         else check("bresp", bresp, wr_exp_q.pop_front());
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_write(input logic [31:0] off, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] er);
      bit aw_ok = 0, w_ok = 0, fa, fw;
      int n = 0;
      wr_exp_q.push_back(er);
      @(posedge clk); #1;
      awaddr = BASE + off; awvalid = 1'b1;
      wdata = d; wstrb = {4'b0000, s}; wvalid = 1'b1;
      while (!(aw_ok && w_ok) && n < 100) begin
         @(negedge clk);
         fa = awvalid && awready;
         fw = wvalid && wready;
         @(posedge clk); #1;
         if (fa) begin aw_ok = 1; awvalid = 1'b0; end
         if (fw) begin w_ok = 1; wvalid = 1'b0; end
         n++;
      end
      if (!(aw_ok && w_ok)) check_true("wr_addr_data_timeout", 1'b0, off);
      awvalid = 1'b0; wvalid = 1'b0;
      bready = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!bvalid && n < 100);
      if (!bvalid) check_true("wr_bvalid_timeout", 1'b0, off);
      @(posedge clk); #1;
      bready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] off, input bit chk, input logic [31:0] ed,
                          input logic [1:0] er, output logic [31:0] got);
      int n = 0;
      rd_exp_q.push_back('{chk: chk, resp: er, data: ed});
      @(posedge clk); #1;
      araddr = BASE + off; arvalid = 1'b1;
      do begin @(negedge clk); n++; end while (!arready && n < 100);
      if (!arready) check_true("rd_arready_timeout", 1'b0, off);
      @(posedge clk); #1;
      arvalid = 1'b0; rready = 1'b1;
      n = 0;
      while (!rvalid && n < 100) begin @(negedge clk); n++; end
      if (!rvalid) check_true("rd_rvalid_timeout", 1'b0, off);
      got = rdata;
      @(posedge clk); #1;
      rready = 1'b0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [31:0] got;
      int t0, n, delta, seen;

      //            wr  off        wdata         strb     resp   rdata         msip
      vecs.push_back('{1, 32'h200, 32'h1234_5678, 4'hF,   2'b00, 32'h0,        2'b00});
      vecs.push_back('{1, 32'h204, 32'h0000_00AB, 4'hF,   2'b00, 32'h0,        2'b00});
      vecs.push_back('{0, 32'h200, 32'h0,         4'h0,   2'b00, 32'h1234_5678, 2'b00});
      vecs.push_back('{0, 32'h204, 32'h0,         4'h0,   2'b00, 32'h0000_00AB, 2'b00});
      vecs.push_back('{1, 32'h200, 32'hAABB_CCDD, 4'b0101, 2'b00, 32'h0,        2'b00});
      vecs.push_back('{0, 32'h200, 32'h0,         4'h0,   2'b00, 32'h12BB_56DD, 2'b00});
      vecs.push_back('{1, 32'h208, 32'hDEAD_BEEF, 4'h0,   2'b00, 32'h0,        2'b00});
      vecs.push_back('{0, 32'h208, 32'h0,         4'h0,   2'b00, 32'hFFFF_FFFF, 2'b00});
      vecs.push_back('{1, 32'h104, 32'h0000_0001, 4'b0001, 2'b00, 32'h0,        2'b10});
      vecs.push_back('{1, 32'h104, 32'h0000_0000, 4'h0,   2'b00, 32'h0,        2'b10});
      vecs.push_back('{0, 32'h104, 32'h0,         4'h0,   2'b00, 32'h0000_0001, 2'b10});
      vecs.push_back('{1, 32'h100, 32'h0000_0003, 4'hF,   2'b00, 32'h0,        2'b11});
      vecs.push_back('{0, 32'h100, 32'h0,         4'h0,   2'b00, 32'h0000_0001, 2'b11});
      vecs.push_back('{1, 32'h104, 32'hFFFF_FFFE, 4'hF,   2'b00, 32'h0,        2'b01});
      vecs.push_back('{0, 32'h104, 32'h0,         4'h0,   2'b00, 32'h0000_0000, 2'b01});
      vecs.push_back('{1, 32'h104, 32'h0000_0001, 4'b0001, 2'b00, 32'h0,        2'b11});
      vecs.push_back('{0, 32'h108, 32'h0,         4'h0,   2'b10, 32'h0,        2'b11});
      vecs.push_back('{0, 32'h300, 32'h0,         4'h0,   2'b10, 32'h0,        2'b11});
      vecs.push_back('{1, 32'h300, 32'h1234_5678, 4'hF,   2'b10, 32'h0,        2'b11});
      vecs.push_back('{1, 32'h210, 32'h0,         4'hF,   2'b10, 32'h0,        2'b11});
      vecs.push_back('{0, 32'h20C, 32'h0,         4'h0,   2'b00, 32'hFFFF_FFFF, 2'b11});
      vecs.push_back('{0, 32'h002, 32'h0,         4'h0,   2'b10, 32'h0,        2'b11});

      // Reset state.
      repeat (3) @(negedge clk);
      check("reset_handshake_outputs", {arready, awready, wready, rvalid, bvalid, rresp, bresp}, 9'd0);
      check("reset_rdata", rdata, 32'd0);
      check("reset_irq", {mtip, msip}, 4'd0);
      reset = 1'b1;
      repeat (10) @(posedge clk);
      do_read(32'h000, 1'b0, 32'd0, 2'b00, got);
      check_true("mtime_counts_after_reset", got >= 32'd10, got);
      @(negedge clk);
      check("irq_after_release", {mtip, msip}, 4'd0);

      // Register table.
      foreach (vecs[i]) begin
         if (vecs[i].is_wr) do_write(vecs[i].off, vecs[i].wdata, vecs[i].strb, vecs[i].resp);
         else               do_read(vecs[i].off, 1'b1, vecs[i].rdata, vecs[i].resp, got);
         @(negedge clk);
         check($sformatf("vec%0d_msip", i), msip, vecs[i].msip);
      end
      check("mtip_cmp_high", mtip, 2'b00);

      // Timer interrupt: restart mtime from 0 and time the compare against 0x20.
      do_write(32'h004, 32'h0, 4'hF, 2'b00);
      do_write(32'h000, 32'h0, 4'hF, 2'b00);
      t0 = cyc;
      do_write(32'h200, 32'h20, 4'hF, 2'b00);
      do_write(32'h204, 32'h0, 4'hF, 2'b00);
      @(negedge clk);
      check("mtip_before_match", mtip[0], 1'b0);
      n = 0;
      do begin @(negedge clk); n++; end while (!mtip[0] && n < 200);
      delta = cyc - t0;
      check_true("mtip_rise_time", mtip[0] && delta >= 32'h1F && delta <= 32'h21, delta);
      check("mtip_other_hart", mtip[1], 1'b0);
      do_write(32'h204, 32'h1, 4'hF, 2'b00);
      @(negedge clk);
      check("mtip_cleared_by_cmp_hi", mtip[0], 1'b0);

      // Coherent 64-bit read across a low-word carry.
      do_write(32'h004, 32'h0, 4'hF, 2'b00);
      do_write(32'h000, 32'hFFFF_FFC0, 4'hF, 2'b00);
      do_read(32'h000, 1'b0, 32'd0, 2'b00, got);
      check_true("mtime_lo_near_carry", got >= 32'hFFFF_FFC0 && got < 32'hFFFF_FFF0, got);
      repeat (80) @(posedge clk);
      do_read(32'h004, 1'b1, 32'h0, 2'b00, got);
      do_read(32'h004, 1'b1, 32'h1, 2'b00, got);

      // W presented three cycles ahead of AW.
      wr_exp_q.push_back(2'b00);
      @(posedge clk); #1;
      wdata = 32'h5555_0000; wstrb = 8'h0F; wvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!wready && n < 100);
      @(posedge clk); #1;
      wvalid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("no_bvalid_without_aw", bvalid, 1'b0);
      @(posedge clk); #1;
      awaddr = BASE + 32'h208; awvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!awready && n < 100);
      @(posedge clk); #1;
      awvalid = 1'b0; bready = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!bvalid && n < 100);
      check("split_write_bvalid", bvalid, 1'b1);
      @(posedge clk); #1;
      bready = 1'b0;

      // Read with rready held low for five cycles.
      rd_exp_q.push_back('{chk: 1'b1, resp: 2'b00, data: 32'h5555_0000});
      araddr = BASE + 32'h208; arvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!arready && n < 100);
      @(posedge clk); #1;
      arvalid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("stall%0d_rvalid", k), rvalid, 1'b1);
         check($sformatf("stall%0d_rdata", k), rdata, 32'h5555_0000);
      end
      @(posedge clk); #1;
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
      @(negedge clk);
      check("rvalid_after_accept", rvalid, 1'b0);

      // Unmapped read, then reset while the response is pending.
      @(posedge clk); #1;
      araddr = BASE + 32'h300; arvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!arready && n < 100);
      @(posedge clk); #1;
      arvalid = 1'b0;
      @(negedge clk);
      check("unmapped_rvalid", rvalid, 1'b1);
      check("unmapped_rresp", rresp, 2'b10);
      check("unmapped_rdata", rdata, 32'h0);
      #2 reset = 1'b0;
      #1;
      check("reset_drops_rvalid", rvalid, 1'b0);
      check("reset_drops_arready", arready, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      rready = 1'b1;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (rvalid) seen++;
      end
      rready = 1'b0;
      check("no_response_after_reset", seen, 0);
      check("irq_after_second_reset", {mtip, msip}, 4'd0);
      do_read(32'h200, 1'b1, 32'hFFFF_FFFF, 2'b00, got);
      do_read(32'h104, 1'b1, 32'h0, 2'b00, got);

      repeat (3) @(negedge clk);
      check("rd_queue_drained", rd_exp_q.size(), 0);
      check("wr_queue_drained", wr_exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
